// File: rtl/adc_lvds_cfg_pkg.sv
// Shared types and constants for the ADC LVDS configuration sequencer.
// The sequencer programs the ADC slave's registers over AXI4-Lite.
package adc_lvds_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_NEXT = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BRESP    = 3'd1;
    localparam logic [2:0] ERR_RRESP    = 3'd2;
    localparam logic [2:0] ERR_MISMATCH = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Byte offset of a 32-bit register slot relative to the block base.
    function automatic logic [5:0] reg_offset(input logic [3:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/adc_lvds_cfg_axi_if.sv
// AXI4-Lite bundle between the configuration sequencer (master) and the ADC register slave.
// A beat transfers on a rising edge where valid and ready are both high; once raised, valid and its payload hold until that edge.
interface adc_lvds_cfg_axi_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/adc_lvds_cfg_timeout.sv
// Per-phase watchdog: clr reloads, en counts down, expired flags the CYCLES-th cycle
// spent waiting since the last reload.
module adc_lvds_cfg_timeout #(
    parameter int unsigned CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/adc_lvds_cfg_sequencer.sv
// AXI4-Lite master that writes a table of words to consecutive ADC registers and,
// optionally, reads each one back to confirm it stuck.
module adc_lvds_cfg_sequencer
    import adc_lvds_cfg_pkg::*;
#(
    parameter int unsigned           NUM_REGS       = 4,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h43C0_0000),
    parameter bit                    VERIFY         = 1'b1,
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           start_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_data_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic [2:0]                     err_code_o,
    output logic [3:0]                     err_index_o,
    output state_t                         state_o,
    adc_lvds_cfg_axi_if.master             m_axi
);

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [2:0]              err_code_q, err_code_d;
    logic [3:0]              err_index_q, err_index_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wvalid_q, wvalid_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    bready_q, bready_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;

    logic                    fail;
    logic [2:0]              fail_code;
    logic                    aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                    tmo_clr, tmo_en, tmo_expired;
    logic [DATA_WIDTH-1:0]   cfg_words [16];

    // Pad the table to 16 slots so any 4-bit index selects a defined word.
    for (genvar g = 0; g < 16; g++) begin : g_words
        if (g < NUM_REGS) begin : g_used
            assign cfg_words[g] = cfg_data_i[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign cfg_words[g] = '0;
        end
    end

    assign aw_fire = awvalid_q & m_axi.awready;
    assign w_fire  = wvalid_q  & m_axi.wready;
    assign b_fire  = bready_q  & m_axi.bvalid;
    assign ar_fire = arvalid_q & m_axi.arready;
    assign r_fire  = rready_q  & m_axi.rvalid;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_WR;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                    awaddr_d    = BASE_ADDR;
                    wdata_d     = cfg_words[0];
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                end
            end

            // AW and W complete independently; each valid drops right after its own beat.
            ST_WR: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end else if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            ST_WB: begin
                if (b_fire) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != AXI_RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_BRESP;
                    end else if (VERIFY) begin
                        state_d   = ST_RA;
                        araddr_d  = awaddr_q;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            ST_RA: begin
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD;
                end else if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            ST_RD: begin
                if (r_fire) begin
                    rready_d = 1'b0;
                    if (m_axi.rresp != AXI_RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RRESP;
                    end else if (m_axi.rdata != wdata_q) begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end

            ST_NEXT: begin
                if (idx_q == 4'(NUM_REGS - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d   = ST_WR;
                    idx_d     = idx_q + 4'd1;
                    awaddr_d  = BASE_ADDR + ADDR_WIDTH'(reg_offset(idx_d));
                    wdata_d   = cfg_words[idx_d];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any failure aborts the bus activity at once and records where it happened.
        if (fail) begin
            state_d     = ST_ERR;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_code_d  = fail_code;
            err_index_d = idx_q;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    // Watchdog restarts whenever the FSM changes state and runs only while awaiting a beat.
    assign tmo_clr = (state_d != state_q);
    assign tmo_en  = state_q inside {ST_WR, ST_WB, ST_RA, ST_RD};

    adc_lvds_cfg_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_code_o  = err_code_q;
    assign err_index_o = err_index_q;
    assign state_o     = state_q;

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule
